ch_readout_sequencer: RTL and testbench
=======================================

Name: ch_readout_sequencer

Overview:
Chip-level readout scheduler that shares the single serializer/readout path among the N_CH channel state machines.
- On a readout request it freezes all channels with a global stop.
- It snapshots each channel's trigger count.
- It then walks the channels in ascending order. For each channel it drives a one-hot readout select and sequences that channel's filled fast buffers one at a time.
- It sits between slow control and the per-channel state machines and serializer, in the system clock domain.

Parameters:
N_CH, 8, number of channels.
WORDS_PER_BUF, 64, serializer words transferred per fast buffer.
SETTLE_CYC, 4, cycles to hold inst_stop, and to hold inst_readout before the first word request.
MAX_BUFS, 4, fast buffers per channel; counts above this are clamped.

Ports:
CLK  in  1  system clock, rising edge.
RSTB  in  1  reset, asynchronous, active-low.
readout_req  in  1  single-cycle pulse that starts a readout.
abort  in  1  single-cycle pulse that returns the block to IDLE.
trigger_cnt_i  in  3*N_CH  per-channel trigger_cnt; channel k occupies bits [3k+2:3k].
inst_stop  out  1  global stop to all channels.
inst_readout  out  N_CH  one-hot readout select.
buf_sel  out  2  fast buffer currently being read.
ch_idx  out  $clog2(N_CH)  channel currently being scanned or read.
word_req  out  1  requests words from the serializer.
word_ack  in  1  one pulse per word transferred.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when readout completes.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; snapshot cleared.
- IDLE
  - A readout_req goes to STOP on the next edge.
  - If abort and readout_req are asserted in the same cycle, abort wins and the block stays in IDLE.
- STOP
  - inst_stop=1 for exactly SETTLE_CYC cycles.
  - On the last of those cycles, trigger_cnt_i is latched into the snapshot.
  - Next state is SCAN with ch_idx=0.
  - Later changes on trigger_cnt_i are ignored until the next readout.
- SCAN
  - Examines one channel per cycle.
  - Channel snapshot = 0: increment ch_idx. Past N_CH-1, go to DONE.
  - Channel snapshot != 0: nbuf = min(snap, MAX_BUFS); buf_sel=0; go to SELECT.
- SELECT
  - inst_readout[ch_idx]=1 for SETTLE_CYC cycles, then go to XFER.
- XFER
  - word_req=1 throughout. Each word_ack increments word_cnt.
  - word_ack while word_req=0 is ignored.
  - When the WORDS_PER_BUF-th ack arrives, word_req drops on the next cycle and word_cnt clears.
  - If buf_sel < nbuf-1: increment buf_sel and stay in XFER. There is one idle cycle with word_req=0, and no re-settle.
  - Otherwise: inst_readout drops, ch_idx increments, and the block goes to SCAN, or to DONE after the last channel.
- inst_readout holds through SELECT and XFER of a channel and is 0 for at least one cycle between channels.
- DONE
  - done=1 for one cycle, then IDLE; busy drops in that same IDLE cycle.
- readout_req while busy: ignored.
- abort in any state other than IDLE: the next state is IDLE.
  - All outputs go to 0.
  - No done pulse.
  - Counters and snapshot are cleared.
- RSTB low mid-operation: immediate asynchronous return to the reset values.
- Counter widths: word_cnt is $clog2(WORDS_PER_BUF+1) bits; settle counter is $clog2(SETTLE_CYC+1) bits; buf_sel is 2 bits and never wraps, because it is bounded by nbuf.

Optional Feature:
Macro name: PSEC_RDSEQ_HEADER_EN.
- When defined:
  - Extra ports hdr_valid (out, 1), hdr_data (out, $clog2(N_CH)+3) and hdr_ready (in, 1) are present.
  - After SELECT and before the first XFER of each channel, the block enters state HDR.
  - In HDR, hdr_valid=1 and hdr_data={ch_idx, snapshot[ch_idx]}; the raw, unclamped count is sent.
  - The block holds in HDR until hdr_ready=1, then goes to XFER on the next edge.
  - abort in HDR is honoured.
- When undefined: the ports and the HDR state do not exist, and SELECT goes directly to XFER.

Decomposition:
- types_pkg gains:
  - enum rdseq_state_t {RDSEQ_IDLE, RDSEQ_STOP, RDSEQ_SCAN, RDSEQ_SELECT, RDSEQ_HDR, RDSEQ_XFER, RDSEQ_DONE};
  - localparam RDSEQ_MAX_BUFS=4;
  - function clamp_nbuf(logic [2:0]) returning logic [2:0].
- No sub-module. The FSM and its three counters stay in one module; the settle counter is shared between STOP and SELECT.

Test Plan:
(Bench configuration: N_CH=8, WORDS_PER_BUF=4, SETTLE_CYC=2, header macro off unless stated; ack every cycle.)
1. ch0=1, all other channels 0; readout_req -> inst_stop high 2 cycles; inst_readout=8'h01; buf_sel=0; exactly 4 acks accepted; one done pulse; busy low after.
2. ch2=4, ch5=2, ch7=7 -> order ch2 buf0..3, ch5 buf0..1, ch7 buf0..3 (clamped); 40 acks total; inst_readout is 8'h04, then 8'h20, then 8'h80, with gaps of 0 between channels.
3. All counts 0 -> inst_readout never asserted; word_req never asserted; done one cycle after SCAN reaches ch7.
4. abort during ch3 XFER after 2 acks -> next cycle IDLE with all outputs 0 and no done; a following readout_req restarts at ch0.
5. Change trigger_cnt_i mid-XFER and pulse word_ack while word_req=0, plus readout_req while busy -> no effect on sequence or counts.
6. Header macro defined, ch5=2, hdr_ready held low for 3 cycles -> hdr_valid held with hdr_data={3'd5,3'd2}; XFER begins the cycle after hdr_ready=1.

Source files
------------

// File: rtl/ch_readout_sequencer_pkg.sv
// Shared types for the chip readout sequencer: FSM state encoding and the
// fast-buffer clamp helper.
package ch_readout_sequencer_pkg;

  typedef enum logic [2:0] {
    RDSEQ_IDLE,
    RDSEQ_STOP,
    RDSEQ_SCAN,
    RDSEQ_SELECT,
    RDSEQ_HDR,
    RDSEQ_XFER,
    RDSEQ_DONE
  } rdseq_state_t;

  localparam int unsigned RDSEQ_MAX_BUFS = 4;

  function automatic logic [2:0] clamp_nbuf(input logic [2:0] cnt);
    return (cnt > 3'(RDSEQ_MAX_BUFS)) ? 3'(RDSEQ_MAX_BUFS) : cnt;
  endfunction

endpackage

// File: rtl/ch_readout_sequencer.sv
// Chip-level readout scheduler: stops all channels, snapshots trigger counts and
// walks channels in order through the shared serializer. Option: PSEC_RDSEQ_HEADER_EN.
module ch_readout_sequencer
  import ch_readout_sequencer_pkg::*;
#(
  parameter int unsigned N_CH          = 8,
  parameter int unsigned WORDS_PER_BUF = 64,
  parameter int unsigned SETTLE_CYC    = 4,
  parameter int unsigned MAX_BUFS      = RDSEQ_MAX_BUFS
) (
  input  logic                      CLK,
  input  logic                      RSTB,
  input  logic                      readout_req,
  input  logic                      abort,
  input  logic [3*N_CH-1:0]         trigger_cnt_i,
  output logic                      inst_stop,
  output logic [N_CH-1:0]           inst_readout,
  output logic [1:0]                buf_sel,
  output logic [$clog2(N_CH)-1:0]   ch_idx,
  output logic                      word_req,
  input  logic                      word_ack,
  output logic                      busy,
`ifdef PSEC_RDSEQ_HEADER_EN
  output logic                      hdr_valid,
  output logic [$clog2(N_CH)+2:0]   hdr_data,
  input  logic                      hdr_ready,
`endif
  output logic                      done
);

  localparam int unsigned CW = $clog2(N_CH);
  localparam int unsigned WW = $clog2(WORDS_PER_BUF + 1);
  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);

  localparam logic [CW-1:0] LAST_CH     = CW'(N_CH - 1);
  localparam logic [WW-1:0] WORDS       = WW'(WORDS_PER_BUF);
  localparam logic [WW-1:0] LAST_WORD   = WW'(WORDS_PER_BUF - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [2:0]    MAX_NBUF    = 3'(MAX_BUFS);

  rdseq_state_t        state, state_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [1:0]          buf_q, buf_d;
  logic [2:0]          nbuf_q, nbuf_d;
  logic [WW-1:0]       wcnt_q, wcnt_d;
  logic [3*N_CH-1:0]   snap_q, snap_d;

  logic [2:0] cur_cnt, pkg_nbuf, cur_nbuf;

  assign cur_cnt  = snap_q[3*int'(ch_q) +: 3];
  assign pkg_nbuf = clamp_nbuf(cur_cnt);
  assign cur_nbuf = (pkg_nbuf > MAX_NBUF) ? MAX_NBUF : pkg_nbuf;

  assign ch_idx  = ch_q;
  assign buf_sel = buf_q;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state    <= RDSEQ_IDLE;
      settle_q <= '0;
      ch_q     <= '0;
      buf_q    <= '0;
      nbuf_q   <= '0;
      wcnt_q   <= '0;
      snap_q   <= '0;
    end else begin
      state    <= state_d;
      settle_q <= settle_d;
      ch_q     <= ch_d;
      buf_q    <= buf_d;
      nbuf_q   <= nbuf_d;
      wcnt_q   <= wcnt_d;
      snap_q   <= snap_d;
    end
  end

  always_comb begin
    state_d      = state;
    settle_d     = settle_q;
    ch_d         = ch_q;
    buf_d        = buf_q;
    nbuf_d       = nbuf_q;
    wcnt_d       = wcnt_q;
    snap_d       = snap_q;
    inst_stop    = 1'b0;
    inst_readout = '0;
    word_req     = 1'b0;
    busy         = (state != RDSEQ_IDLE);
    done         = 1'b0;
`ifdef PSEC_RDSEQ_HEADER_EN
    hdr_valid    = 1'b0;
    hdr_data     = '0;
`endif

    case (state)
      RDSEQ_IDLE: begin
        if (readout_req && !abort) begin
          state_d  = RDSEQ_STOP;
          settle_d = '0;
        end
      end

      RDSEQ_STOP: begin
        inst_stop = 1'b1;
        if (settle_q == SETTLE_LAST) begin
          snap_d   = trigger_cnt_i;
          settle_d = '0;
          ch_d     = '0;
          state_d  = RDSEQ_SCAN;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      RDSEQ_SCAN: begin
        if (cur_cnt == 3'd0) begin
          if (ch_q == LAST_CH) state_d = RDSEQ_DONE;
          else                 ch_d    = ch_q + 1'b1;
        end else begin
          nbuf_d   = cur_nbuf;
          buf_d    = '0;
          wcnt_d   = '0;
          settle_d = '0;
          state_d  = RDSEQ_SELECT;
        end
      end

      RDSEQ_SELECT: begin
        inst_readout[ch_q] = 1'b1;
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
`ifdef PSEC_RDSEQ_HEADER_EN
          state_d  = RDSEQ_HDR;
`else
          state_d  = RDSEQ_XFER;
`endif
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

`ifdef PSEC_RDSEQ_HEADER_EN
      RDSEQ_HDR: begin
        inst_readout[ch_q] = 1'b1;
        hdr_valid          = 1'b1;
        hdr_data           = {ch_q, cur_cnt};
        if (hdr_ready) state_d = RDSEQ_XFER;
      end
`endif

      RDSEQ_XFER: begin
        inst_readout[ch_q] = 1'b1;
        // wcnt_q == WORDS marks the single idle cycle between buffers of a channel
        if (wcnt_q == WORDS) begin
          wcnt_d = '0;
        end else begin
          word_req = 1'b1;
          if (word_ack) begin
            if (wcnt_q == LAST_WORD) begin
              if (({1'b0, buf_q} + 3'd1) < nbuf_q) begin
                buf_d  = buf_q + 1'b1;
                wcnt_d = WORDS;
              end else begin
                buf_d  = '0;
                wcnt_d = '0;
                if (ch_q == LAST_CH) begin
                  state_d = RDSEQ_DONE;
                end else begin
                  ch_d    = ch_q + 1'b1;
                  state_d = RDSEQ_SCAN;
                end
              end
            end else begin
              wcnt_d = wcnt_q + 1'b1;
            end
          end
        end
      end

      RDSEQ_DONE: begin
        done     = 1'b1;
        ch_d     = '0;
        buf_d    = '0;
        nbuf_d   = '0;
        wcnt_d   = '0;
        settle_d = '0;
        state_d  = RDSEQ_IDLE;
      end

      default: state_d = RDSEQ_IDLE;
    endcase

    if (abort && state != RDSEQ_IDLE) begin
      state_d  = RDSEQ_IDLE;
      settle_d = '0;
      ch_d     = '0;
      buf_d    = '0;
      nbuf_d   = '0;
      wcnt_d   = '0;
      snap_d   = '0;
    end
  end

endmodule

// File: tb/tb_ch_readout_sequencer.sv
// Self-checking bench for ch_readout_sequencer (N_CH=8, WORDS_PER_BUF=4, SETTLE_CYC=2);
// header-path step is compiled in when PSEC_RDSEQ_HEADER_EN is defined.
module tb_ch_readout_sequencer;

  localparam int N_CH   = 8;
  localparam int WPB    = 4;
  localparam int SETTLE = 2;

  typedef logic [2:0] snap_t [N_CH];

  logic        CLK = 1'b0;
  logic        RSTB = 1'b0;
  logic        readout_req = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] trigger_cnt_i = '0;
  logic        inst_stop;
  logic [7:0]  inst_readout;
  logic [1:0]  buf_sel;
  logic [2:0]  ch_idx;
  logic        word_req;
  logic        word_ack = 1'b0;
  logic        busy;
  logic        done;
`ifdef PSEC_RDSEQ_HEADER_EN
  logic        hdr_valid;
  logic [5:0]  hdr_data;
  logic        hdr_ready = 1'b1;
  localparam int HDR_EXTRA = 1;
`else
  localparam int HDR_EXTRA = 0;
`endif

  always #5 CLK = ~CLK;

  ch_readout_sequencer #(
    .N_CH(N_CH), .WORDS_PER_BUF(WPB), .SETTLE_CYC(SETTLE), .MAX_BUFS(4)
  ) dut (
    .CLK(CLK), .RSTB(RSTB), .readout_req(readout_req), .abort(abort),
    .trigger_cnt_i(trigger_cnt_i), .inst_stop(inst_stop), .inst_readout(inst_readout),
    .buf_sel(buf_sel), .ch_idx(ch_idx), .word_req(word_req), .word_ack(word_ack),
    .busy(busy),
`ifdef PSEC_RDSEQ_HEADER_EN
    .hdr_valid(hdr_valid), .hdr_data(hdr_data), .hdr_ready(hdr_ready),
`endif
    .done(done)
  );

  int checks = 0;
  int errors = 0;

  int stop_cyc, done_cnt, busy_cyc, wreq_cyc, bad_sel;
  logic [7:0] prev_ro;
  logic [7:0] ro_q[$];
  int acc_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int outs();
    return int'({inst_stop, inst_readout, buf_sel, ch_idx, word_req, busy, done});
  endfunction

  function automatic logic [23:0] pack(input snap_t s);
    logic [23:0] v = '0;
    for (int k = 0; k < N_CH; k++) v[3*k +: 3] = s[k];
    return v;
  endfunction

  task automatic clear_mon();
    stop_cyc = 0; done_cnt = 0; busy_cyc = 0; wreq_cyc = 0; bad_sel = 0;
    ro_q.delete(); acc_q.delete();
    prev_ro = inst_readout;
  endtask

  // sample mid-cycle, then advance to just after the next rising edge
  task automatic tick();
    @(negedge CLK);
    if (inst_stop) stop_cyc++;
    if (done) done_cnt++;
    if (busy) busy_cyc++;
    if (word_req) begin
      wreq_cyc++;
      if (word_ack) begin
        acc_q.push_back(int'(ch_idx) * 8 + int'(buf_sel));
        if (inst_readout !== (8'd1 << ch_idx)) bad_sel++;
      end
    end
    if (inst_readout !== prev_ro) begin
      ro_q.push_back(inst_readout);
      prev_ro = inst_readout;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic run_readout(input string tag, input snap_t s, input bit rand_ack, input bit disturb);
    int exp_acc[$];
    logic [7:0] exp_ro[$];
    int exp_busy = 3;
    int nb, mism;
    for (int k = 0; k < N_CH; k++) begin
      if (s[k] == 0) exp_busy += 1;
      else begin
        nb = (s[k] > 4) ? 4 : int'(s[k]);
        exp_busy += 5 * nb + 2 + HDR_EXTRA;
        for (int b = 0; b < nb; b++)
          for (int w = 0; w < WPB; w++) exp_acc.push_back(k * 8 + b);
        exp_ro.push_back(8'd1 << k);
        exp_ro.push_back(8'h00);
      end
    end

    clear_mon();
    readout_req = 1'b1; word_ack = 1'b1; trigger_cnt_i = 24'($urandom);
    tick();
    readout_req = 1'b0; trigger_cnt_i = 24'($urandom);
    tick();
    trigger_cnt_i = pack(s);
    tick();
    if (disturb) trigger_cnt_i = 24'($urandom);
    for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
      word_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      if (disturb) begin
        readout_req = busy && !done && ($urandom_range(0, 3) == 0);
        if (word_req && $urandom_range(0, 3) == 0) trigger_cnt_i = 24'($urandom);
      end
      tick();
    end
    readout_req = 1'b0; word_ack = 1'b0;
    check({tag, "_idle_after_done"}, outs(), 0);
    tick();
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_stop_cycles"}, stop_cyc, SETTLE);
    check({tag, "_ack_count"}, acc_q.size(), exp_acc.size());
    mism = 0;
    for (int i = 0; i < exp_acc.size(); i++)
      if (i >= acc_q.size() || acc_q[i] != exp_acc[i]) mism++;
    check({tag, "_ack_order"}, mism, 0);
    mism = (ro_q.size() == exp_ro.size()) ? 0 : 1;
    for (int i = 0; i < exp_ro.size() && i < ro_q.size(); i++)
      if (ro_q[i] !== exp_ro[i]) mism++;
    check({tag, "_readout_seq"}, mism, 0);
    check({tag, "_sel_onehot"}, bad_sel, 0);
    if (!rand_ack) begin
      check({tag, "_busy_cycles"}, busy_cyc, exp_busy);
      check({tag, "_wreq_cycles"}, wreq_cyc, exp_acc.size());
    end
  endtask

  initial begin
    snap_t s;
    int ch3;

    // reset values
    #1;
    check("reset_outputs", outs(), 0);
    repeat (3) @(posedge CLK);
    #1 RSTB = 1'b1;
    tick();
    check("idle_after_reset", outs(), 0);

    // 1: single channel, single buffer
    s = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run_readout("t1", s, 1'b0, 1'b0);

    // 2: three channels, ch7 clamped to 4 buffers
    s = '{3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd2, 3'd0, 3'd7};
    run_readout("t2", s, 1'b0, 1'b0);

    // 3: nothing to read
    s = '{default: 3'd0};
    run_readout("t3", s, 1'b0, 1'b0);

    // abort and readout_req together in IDLE
    clear_mon();
    readout_req = 1'b1; abort = 1'b1;
    tick();
    readout_req = 1'b0; abort = 1'b0;
    check("abort_req_idle_busy", int'(busy), 0);
    tick();
    check("abort_req_idle_stop", stop_cyc, 0);

    // 4: abort during ch3 transfer after 2 acks
    s = '{3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
    clear_mon();
    trigger_cnt_i = pack(s); readout_req = 1'b1; word_ack = 1'b1;
    tick();
    readout_req = 1'b0;
    ch3 = 0;
    for (int n = 0; n < 200 && ch3 < 2; n++) begin
      tick();
      ch3 = 0;
      foreach (acc_q[i]) if (acc_q[i] / 8 == 3) ch3++;
    end
    check("abort_ch3_acks", ch3, 2);
    abort = 1'b1; word_ack = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_outputs", outs(), 0);
    repeat (5) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_stays_idle", int'(busy), 0);
    s = '{3'd1, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
    run_readout("t4_restart", s, 1'b0, 1'b0);

    // 5: disturbances during the transfer, random ack pacing
    s = '{3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 3'd6, 3'd0, 3'd0};
    run_readout("t5", s, 1'b0, 1'b1);
    run_readout("t5_rack", s, 1'b1, 1'b1);

    // randomized snapshots
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N_CH; k++)
        s[k] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      run_readout($sformatf("rnd%0d", r), s, 1'(r % 2), 1'b1);
    end

    // asynchronous reset mid-transfer
    s = '{3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    clear_mon();
    trigger_cnt_i = pack(s); readout_req = 1'b1; word_ack = 1'b1;
    tick();
    readout_req = 1'b0;
    for (int n = 0; n < 200 && !(word_req && buf_sel == 2'd1); n++) tick();
    check("rst_midop_reached", int'(buf_sel), 1);
    RSTB = 1'b0;
    #1;
    check("rst_midop_outputs", outs(), 0);
    @(posedge CLK);
    #1 RSTB = 1'b1; word_ack = 1'b0;
    tick();
    check("rst_midop_idle", outs(), 0);

`ifdef PSEC_RDSEQ_HEADER_EN
    // 6: header handshake with hdr_ready held off
    s = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0};
    clear_mon();
    hdr_ready = 1'b0; word_ack = 1'b1;
    trigger_cnt_i = pack(s); readout_req = 1'b1;
    tick();
    readout_req = 1'b0;
    for (int n = 0; n < 100 && !hdr_valid; n++) tick();
    for (int i = 0; i < 3; i++) begin
      check("hdr_valid_held", int'(hdr_valid), 1);
      check("hdr_data", int'(hdr_data), int'({3'd5, 3'd2}));
      check("hdr_no_wreq", int'(word_req), 0);
      tick();
    end
    check("hdr_valid_still", int'(hdr_valid), 1);
    hdr_ready = 1'b1;
    tick();
    check("hdr_xfer_starts", int'(word_req), 1);
    check("hdr_valid_drops", int'(hdr_valid), 0);
    for (int n = 0; n < 200 && done_cnt == 0; n++) tick();
    word_ack = 1'b0;
    check("hdr_ack_count", acc_q.size(), 8);
    check("hdr_done", done_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
